// File: rtl/reg_move_pkg.sv
// Shared constants for the register-move sequencer: FSM state encoding and
// the all-strobes-inactive pattern used to park sel_n/we_n.
package reg_move_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;

   // Widest strobe vector supported; users slice the low NREG bits.
   localparam int MAX_NREG = 256;

   // Active-low strobes: all ones means no register selected or written.
   localparam logic [MAX_NREG-1:0] ALL_OFF = {MAX_NREG{1'b1}};

endpackage

// File: rtl/reg_move_ctrl_decode.sv
// reg_idx_decode: turns a register index plus enable into an active-low
// one-hot strobe vector, and flags indices outside 0..NREG-1.
// Out-of-range indices never produce a low strobe bit.
module reg_idx_decode
   import reg_move_pkg::*;
#(
   parameter int AW   = 3,
   parameter int NREG = 8
) (
   input  logic [AW-1:0]   idx,
   input  logic            en,
   output logic [NREG-1:0] sel_n,
   output logic            out_of_range
);

   localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

   logic [AW:0] idx_ext_s;

   assign idx_ext_s    = {1'b0, idx};
   assign out_of_range = (idx_ext_s >= NREG_W);

   // Active-low one-hot: bit i goes low only when enabled and idx equals i.
   always_comb begin
      sel_n = ALL_OFF[NREG-1:0];
      for (int i = 0; i < NREG; i++) begin
         sel_n[i] = ~(en & (idx_ext_s == (AW+1)'(i)));
      end
   end

endmodule

// File: rtl/reg_move_ctrl.sv
// reg_move_ctrl: moves one word between bus registers. A command (src, dst)
// is accepted on cmd_valid & cmd_ready; the controller selects src onto the
// shared read bus for one cycle, captures it, then strobes dst for one write
// cycle and pulses done. Bad indices are rejected with a one-cycle err pulse.
// Optional feature macro: REG_MOVE_IMM_EN adds cmd_imm_en/cmd_imm so a
// command can write an immediate word, skipping the read cycle.
module reg_move_ctrl
   import reg_move_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int NREG  = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [AW-1:0]    cmd_src,
   input  logic [AW-1:0]    cmd_dst,
`ifdef REG_MOVE_IMM_EN
   input  logic             cmd_imm_en,
   input  logic [WIDTH-1:0] cmd_imm,
`endif
   input  logic [WIDTH-1:0] bus_rd,
   output logic [WIDTH-1:0] wr_data,
   output logic [NREG-1:0]  sel_n,
   output logic [NREG-1:0]  we_n,
   output logic             done,
   output logic             err
);

   localparam logic [NREG-1:0] STROBE_OFF = ALL_OFF[NREG-1:0];

   logic [1:0]       state_r;
   logic [NREG-1:0]  sel_n_r;
   logic [NREG-1:0]  we_n_r;
   logic [NREG-1:0]  dst_sel_n_r;
   logic [WIDTH-1:0] data_q_r;
   logic             done_r;
   logic             err_r;

   logic             accept_s;
   logic             imm_sel_s;
   logic [WIDTH-1:0] imm_data_s;
   logic [NREG-1:0]  src_sel_n_s;
   logic [NREG-1:0]  dst_sel_n_s;
   logic             src_oor_s;
   logic             dst_oor_s;
   logic             reject_s;

`ifdef REG_MOVE_IMM_EN
   assign imm_sel_s  = cmd_imm_en;
   assign imm_data_s = cmd_imm;
`else
   assign imm_sel_s  = 1'b0;
   assign imm_data_s = {WIDTH{1'b0}};
`endif

   assign cmd_ready = (state_r == ST_IDLE);
   assign accept_s  = cmd_valid & cmd_ready;
   // Immediate commands never read, so their src index is irrelevant.
   assign reject_s  = dst_oor_s | (src_oor_s & ~imm_sel_s);

   reg_idx_decode #(.AW(AW), .NREG(NREG)) u_src_dec (
      .idx          (cmd_src),
      .en           (accept_s & ~imm_sel_s),
      .sel_n        (src_sel_n_s),
      .out_of_range (src_oor_s)
   );

   reg_idx_decode #(.AW(AW), .NREG(NREG)) u_dst_dec (
      .idx          (cmd_dst),
      .en           (accept_s),
      .sel_n        (dst_sel_n_s),
      .out_of_range (dst_oor_s)
   );

   // Move sequencer: IDLE -> READ -> WRITE -> IDLE, strobes and pulses registered.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_r     <= ST_IDLE;
         sel_n_r     <= STROBE_OFF;
         we_n_r      <= STROBE_OFF;
         dst_sel_n_r <= STROBE_OFF;
         data_q_r    <= {WIDTH{1'b0}};
         done_r      <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         done_r <= 1'b0;
         err_r  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  if (reject_s) begin
                     err_r   <= 1'b1;
                     sel_n_r <= STROBE_OFF;
                     we_n_r  <= STROBE_OFF;
                  end else if (imm_sel_s) begin
                     state_r  <= ST_WRITE;
                     data_q_r <= imm_data_s;
                     sel_n_r  <= dst_sel_n_s;
                     we_n_r   <= dst_sel_n_s;
                  end else begin
                     state_r     <= ST_READ;
                     dst_sel_n_r <= dst_sel_n_s;
                     sel_n_r     <= src_sel_n_s;
                     we_n_r      <= STROBE_OFF;
                  end
               end else begin
                  sel_n_r <= STROBE_OFF;
                  we_n_r  <= STROBE_OFF;
               end
            end
            ST_READ: begin
               // Source word is on the bus this cycle; hand it to the write bus.
               state_r  <= ST_WRITE;
               data_q_r <= bus_rd;
               sel_n_r  <= dst_sel_n_r;
               we_n_r   <= dst_sel_n_r;
            end
            ST_WRITE: begin
               // Destination latched at this edge; release strobes and report.
               state_r <= ST_IDLE;
               sel_n_r <= STROBE_OFF;
               we_n_r  <= STROBE_OFF;
               done_r  <= 1'b1;
            end
            default: begin
               state_r <= ST_IDLE;
               sel_n_r <= STROBE_OFF;
               we_n_r  <= STROBE_OFF;
            end
         endcase
      end
   end

   assign wr_data = data_q_r;
   assign sel_n   = sel_n_r;
   assign we_n    = we_n_r;
   assign done    = done_r;
   assign err     = err_r;

endmodule

// File: tb/tb_reg_move_ctrl.sv
// Directed bench for reg_move_ctrl with a behavioural register bank and a
// scoreboard of expected move/err events.
module tb_reg_move_ctrl;

   localparam int WIDTH = 16;
   localparam int NREG  = 8;
   localparam int AW    = 4;

   typedef struct packed {
      logic          is_err;
      logic [AW-1:0] dst;
      logic [15:0]   data;
   } exp_t;

   logic             clk = 1'b0;
   logic             rstn;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [AW-1:0]    cmd_src;
   logic [AW-1:0]    cmd_dst;
`ifdef REG_MOVE_IMM_EN
   logic             cmd_imm_en;
   logic [WIDTH-1:0] cmd_imm;
`endif
   logic [WIDTH-1:0] bus_rd;
   logic [WIDTH-1:0] wr_data;
   logic [NREG-1:0]  sel_n;
   logic [NREG-1:0]  we_n;
   logic             done;
   logic             err;

   logic             bank_init;
   logic [WIDTH-1:0] bank [NREG];
   logic [WIDTH-1:0] exp_regs [NREG];
   exp_t             sb_q [$];
   int               n_cmp = 0;
   int               n_err = 0;

   reg_move_ctrl #(.WIDTH(WIDTH), .NREG(NREG), .AW(AW)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_src    (cmd_src),
      .cmd_dst    (cmd_dst),
`ifdef REG_MOVE_IMM_EN
      .cmd_imm_en (cmd_imm_en),
      .cmd_imm    (cmd_imm),
`endif
      .bus_rd     (bus_rd),
      .wr_data    (wr_data),
      .sel_n      (sel_n),
      .we_n       (we_n),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] init_val(input int i);
      case (i)
         2:       init_val = 16'hBEEF;
         4:       init_val = 16'h1234;
         default: init_val = 16'h1100 | 16'(i);
      endcase
   endfunction

   // Shared read bus: the selected register drives it, otherwise it reads 0.
   always_comb begin
      bus_rd = 16'h0000;
      for (int i = 0; i < NREG; i++) begin
         if (!sel_n[i]) bus_rd = bank[i];
      end
   end

   // Register bank: preload, then latch wr_data where sel_n and we_n are both low.
   always @(posedge clk) begin
      for (int i = 0; i < NREG; i++) begin
         if (bank_init) bank[i] <= init_val(i);
         else if (!sel_n[i] && !we_n[i]) bank[i] <= wr_data;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one cycle, then check strobe invariants and retire scoreboard events.
   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      chk("one_sel_low", 32'($countones(~sel_n) <= 1), 32'd1);
      chk("we_without_sel", 32'((~we_n) & sel_n), 32'd0);
      if (done === 1'b1 || err === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_event", 32'({done, err}), 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("event_kind_err", 32'(err), 32'(e.is_err));
            if (!e.is_err) begin
               chk("sb_wr_data", 32'(wr_data), 32'(e.data));
               chk("sb_dst_reg", 32'(bank[e.dst]), 32'(e.data));
            end
         end
      end
   endtask

   task automatic push_move(input int src, input int dst);
      exp_t e;
      e.is_err = 1'b0;
      e.dst    = AW'(dst);
      e.data   = exp_regs[src];
      exp_regs[dst] = exp_regs[src];
      sb_q.push_back(e);
   endtask

   task automatic push_err();
      exp_t e;
      e.is_err = 1'b1;
      e.dst    = '0;
      e.data   = 16'h0000;
      sb_q.push_back(e);
   endtask

   initial begin
      for (int i = 0; i < NREG; i++) exp_regs[i] = init_val(i);
      rstn      = 1'b0;
      bank_init = 1'b1;
      cmd_valid = 1'b0;
      cmd_src   = '0;
      cmd_dst   = '0;
`ifdef REG_MOVE_IMM_EN
      cmd_imm_en = 1'b0;
      cmd_imm    = 16'h0000;
`endif
      @(posedge clk);
      #1;
      step();
      bank_init = 1'b0;
      chk("rst_sel_n", 32'(sel_n), 32'h00FF);
      chk("rst_we_n", 32'(we_n), 32'h00FF);
      chk("rst_wr_data", 32'(wr_data), 32'h0000);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      rstn = 1'b1;
      step();

      // Move 2 -> 5.
      cmd_valid = 1'b1; cmd_src = 4'd2; cmd_dst = 4'd5;
      push_move(2, 5);
      step();
      cmd_valid = 1'b0;
      chk("t1_read_sel_n", 32'(sel_n), 32'h00FB);
      chk("t1_read_we_n", 32'(we_n), 32'h00FF);
      chk("t1_read_ready", 32'(cmd_ready), 32'd0);
      chk("t1_read_done", 32'(done), 32'd0);
      step();
      chk("t1_write_sel_n", 32'(sel_n), 32'h00DF);
      chk("t1_write_we_n", 32'(we_n), 32'h00DF);
      chk("t1_write_data", 32'(wr_data), 32'h0000BEEF);
      chk("t1_write_done", 32'(done), 32'd0);
      step();
      chk("t1_done", 32'(done), 32'd1);
      chk("t1_idle_sel_n", 32'(sel_n), 32'h00FF);
      chk("t1_done_ready", 32'(cmd_ready), 32'd1);

      // Back-to-back: 1 -> 3, then 3 -> 0 with cmd_valid held high.
      cmd_valid = 1'b1; cmd_src = 4'd1; cmd_dst = 4'd3;
      push_move(1, 3);
      step();
      cmd_src = 4'd3; cmd_dst = 4'd0;
      push_move(3, 0);
      chk("t2_busy_ready", 32'(cmd_ready), 32'd0);
      step();
      chk("t2_write1_sel_n", 32'(sel_n), 32'h00F7);
      step();
      chk("t2_done1", 32'(done), 32'd1);
      chk("t2_done1_ready", 32'(cmd_ready), 32'd1);
      step();
      cmd_valid = 1'b0;
      chk("t2_read2_sel_n", 32'(sel_n), 32'h00F7);
      chk("t2_read2_done", 32'(done), 32'd0);
      step();
      chk("t2_write2_sel_n", 32'(sel_n), 32'h00FE);
      chk("t2_write2_data", 32'(wr_data), 32'(init_val(1)));
      step();
      chk("t2_done2", 32'(done), 32'd1);

      // Out-of-range destination.
      cmd_valid = 1'b1; cmd_src = 4'd1; cmd_dst = 4'd9;
      push_err();
      step();
      cmd_valid = 1'b0;
      chk("t3_err", 32'(err), 32'd1);
      chk("t3_sel_n", 32'(sel_n), 32'h00FF);
      chk("t3_we_n", 32'(we_n), 32'h00FF);
      chk("t3_ready", 32'(cmd_ready), 32'd1);
      chk("t3_done", 32'(done), 32'd0);
      step();
      chk("t3_err_gone", 32'(err), 32'd0);
      chk("t3_no_done", 32'(done), 32'd0);

      // Reset asserted during the WRITE cycle of 6 -> 7; no done may follow.
      cmd_valid = 1'b1; cmd_src = 4'd6; cmd_dst = 4'd7;
      step();
      cmd_valid = 1'b0;
      step();
      chk("t4_write_sel_n", 32'(sel_n), 32'h007F);
      rstn = 1'b0;
      exp_regs[7] = exp_regs[6];
      step();
      chk("t4_rst_sel_n", 32'(sel_n), 32'h00FF);
      chk("t4_rst_we_n", 32'(we_n), 32'h00FF);
      chk("t4_rst_done", 32'(done), 32'd0);
      chk("t4_rst_ready", 32'(cmd_ready), 32'd1);
      rstn = 1'b1;
      step();
      chk("t4_post_done", 32'(done), 32'd0);

      // src == dst == 4 after reset.
      cmd_valid = 1'b1; cmd_src = 4'd4; cmd_dst = 4'd4;
      push_move(4, 4);
      step();
      cmd_valid = 1'b0;
      chk("t5_read_sel_n", 32'(sel_n), 32'h00EF);
      chk("t5_read_we_n", 32'(we_n), 32'h00FF);
      step();
      chk("t5_write_we_n", 32'(we_n), 32'h00EF);
      chk("t5_write_data", 32'(wr_data), 32'h00001234);
      step();
      chk("t5_done", 32'(done), 32'd1);

`ifdef REG_MOVE_IMM_EN
      // Immediate write of 0x00A5 to register 7; src is out of range but ignored.
      cmd_valid = 1'b1; cmd_imm_en = 1'b1; cmd_imm = 16'h00A5;
      cmd_src = 4'd9; cmd_dst = 4'd7;
      begin
         exp_t e;
         e.is_err = 1'b0; e.dst = 4'd7; e.data = 16'h00A5;
         exp_regs[7] = 16'h00A5;
         sb_q.push_back(e);
      end
      step();
      cmd_valid = 1'b0; cmd_imm_en = 1'b0;
      chk("t6_sel_n", 32'(sel_n), 32'h007F);
      chk("t6_we_n", 32'(we_n), 32'h007F);
      chk("t6_data", 32'(wr_data), 32'h000000A5);
      chk("t6_err", 32'(err), 32'd0);
      step();
      chk("t6_done", 32'(done), 32'd1);
`endif

      // Drain: any still-expected event must show up within a short budget.
      for (int k = 0; k < 8 && sb_q.size() != 0; k++) step();
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      for (int i = 0; i < NREG; i++) begin
         chk($sformatf("final_reg%0d", i), 32'(bank[i]), 32'(exp_regs[i]));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
